// File: rtl/tx_pkg.sv
// tx_pkg: shared definitions for the NoC channel transmitter.
//   tx_state_t : transmitter FSM state encoding
//   tx_dbg_t   : debug/observation bundle exported by tx
//   head_bit() : bit position of the head-flit flag in a flit
//   flit_count(): packet length in flits for a given buffer address width
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } tx_state_t;

  // Observation bundle. spurious_ack and missing_head are single-cycle
  // event flags; inst_id/name identify the instance to whatever consumes
  // the bundle (message prefixes in checkers and monitors).
  typedef struct packed {
    tx_state_t   state;
    logic        spurious_ack;
    logic        missing_head;
    logic [7:0]  inst_id;
    logic [63:0] name;
  } tx_dbg_t;

  function automatic int unsigned head_bit(input int unsigned size);
    return size - 1;
  endfunction

  function automatic int unsigned flit_count(input int unsigned buff_bits);
    return 32'd1 << buff_bits;
  endfunction

endpackage

// File: rtl/tx_toggle_detect.sv
// tx_toggle_detect: turns a two-phase (toggle) signal into a one-cycle event.
//   clk   : clock
//   reset : asynchronous active-low reset (registered copy clears to 0)
//   sig   : toggle input from the far side
//   ev    : high while sig differs from its value at the previous edge
// Reusable on the receive side for ch_req.
module tx_toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic ev
);

  logic sig_old;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_old <= 1'b0;
    end else begin
      sig_old <= sig;
    end
  end

  assign ev = sig ^ sig_old;

endmodule

// File: rtl/tx.sv
// tx: NoC router output-port channel transmitter.
// Reads a connected input buffer flit by flit and drives each flit onto the
// inter-router channel, then reports completion back to the switch.
//
// Handshakes:
//   switch side  : four-phase. in_req rises when a complete packet is
//                  connected; in_done rises once every flit is acknowledged
//                  and stays high until in_req is seen low, after which both
//                  return low. in_req falling early is ignored.
//   channel side : two-phase. Each ch_req toggle offers one flit on ch_flit,
//                  which is held stable until the receiver toggles ch_ack.
//                  At most one flit is outstanding.
//
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   in_req     : switch has connected a packet (level)
//   in_done    : packet fully sent (level, held until in_req drops)
//   buf_addr   : read address into the connected buffer
//   buf_data   : combinational read data for buf_addr
//   ch_req     : toggles once per flit offered
//   ch_flit    : flit being offered
//   ch_ack     : toggles once per flit accepted
//   busy       : high whenever the FSM is not idle
//   dbg        : state and event flags for observation
module tx
  import tx_pkg::*;
#(
  parameter int          ID        = 0,
  parameter logic [63:0] MOD_NAME  = "TX",
  parameter int          SIZE      = 8,
  parameter int          BUFF_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req,
  output logic                 in_done,
  output logic [BUFF_BITS-1:0] buf_addr,
  input  logic [SIZE-1:0]      buf_data,
  output logic                 ch_req,
  output logic [SIZE-1:0]      ch_flit,
  input  logic                 ch_ack,
  output logic                 busy,
  output tx_dbg_t              dbg
);

  localparam int unsigned          FLIT_COUNT = flit_count(BUFF_BITS);
  localparam int unsigned          HEAD       = head_bit(SIZE);
  localparam logic [BUFF_BITS-1:0] LAST_ADDR  = BUFF_BITS'(FLIT_COUNT - 1);

  tx_state_t            state_q, state_d;
  logic [BUFF_BITS-1:0] addr_q, addr_d;
  logic                 req_q, req_d;
  logic [SIZE-1:0]      flit_q, flit_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ack_ev;
  logic                 spurious;
  logic                 missing;

  tx_toggle_detect u_ack_detect (
    .clk   (clk),
    .reset (reset),
    .sig   (ch_ack),
    .ev    (ack_ev)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      req_q   <= 1'b0;
      flit_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      flit_q  <= flit_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    req_d    = req_q;
    flit_d   = flit_q;
    done_d   = done_q;
    busy_d   = busy_q;
    spurious = 1'b0;
    missing  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        spurious = ack_ev;
        if (in_req) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An ack here cannot belong to the flit about to be offered.
        spurious = ack_ev;
        missing  = (addr_q == '0) && !buf_data[HEAD];
        flit_d   = buf_data;
        req_d    = ~req_q;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_ev) begin
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        spurious = ack_ev;
        if (!in_req) begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_done  = done_q;
  assign buf_addr = addr_q;
  assign ch_req   = req_q;
  assign ch_flit  = flit_q;
  assign busy     = busy_q;

  assign dbg = '{state:        state_q,
                 spurious_ack: spurious,
                 missing_head: missing,
                 inst_id:      8'(ID),
                 name:         MOD_NAME};

endmodule
